// File: rtl/lsu_if.sv
// Data-memory request/response bus between the load/store unit (master) and data memory (slave).
interface lsu_if #(parameter int ADDR_W = 32);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one data-memory access per LOAD/STORE with lane steering and load extension.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses instead of aligning them down.
module lsu #(
  parameter int ADDR_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] load_data,
  lsu_if.master       mem
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // S_IDLE: waiting for start | S_REQ: bus cycle outstanding | S_RESP: done pulse
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_is_st;
  logic        r_fault;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_sdata;
  logic [31:0] r_load_data;

  logic        w_is_ld;
  logic        w_is_st;
  logic        w_legal;
  logic        w_misalign;
  logic        w_fault;
  logic        w_accept;
  logic [1:0]  w_off;
  logic [31:0] w_rshift;
  logic [31:0] w_ext;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;

  always_comb begin
    w_is_ld  = (opcode == OP_LOAD);
    w_is_st  = (opcode == OP_STORE);
    w_accept = start && (w_is_ld || w_is_st) && (r_state == S_IDLE);
    if (w_is_ld)
      w_legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else
      w_legal = funct3 inside {3'b000, 3'b001, 3'b010};
`ifdef LSU_MISALIGN_TRAP_EN
    w_misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    w_misalign = 1'b0;
`endif
    w_fault = !w_legal || w_misalign;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_fault ? S_RESP : S_REQ;
      S_REQ:  if (mem.mem_ready) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_is_st     <= 1'b0;
      r_fault     <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr      <= 32'h0;
      r_sdata     <= 32'h0;
      r_load_data <= 32'h0;
    end else begin
      if (w_accept) begin
        r_is_st  <= w_is_st;
        r_fault  <= w_fault;
        r_funct3 <= funct3;
        r_addr   <= addr;
        r_sdata  <= store_data;
      end
      if ((r_state == S_REQ) && mem.mem_ready && !r_is_st)
        r_load_data <= w_ext;
    end
  end

  // Halfword offset ignores addr[0] and words ignore addr[1:0], which aligns down when not trapping.
  always_comb begin
    case (r_funct3[1:0])
      2'b00:   w_off = r_addr[1:0];
      2'b01:   w_off = {r_addr[1], 1'b0};
      default: w_off = 2'b00;
    endcase
    w_rshift = mem.mem_rdata >> {w_off, 3'b000};
    case (r_funct3)
      3'b000:  w_ext = {{24{w_rshift[7]}}, w_rshift[7:0]};
      3'b001:  w_ext = {{16{w_rshift[15]}}, w_rshift[15:0]};
      3'b100:  w_ext = {24'h0, w_rshift[7:0]};
      3'b101:  w_ext = {16'h0, w_rshift[15:0]};
      default: w_ext = w_rshift;
    endcase
    case (r_funct3[1:0])
      2'b00: begin
        w_wdata = {4{r_sdata[7:0]}};
        w_wstrb = 4'b0001 << w_off;
      end
      2'b01: begin
        w_wdata = {2{r_sdata[15:0]}};
        w_wstrb = 4'b0011 << w_off;
      end
      default: begin
        w_wdata = r_sdata;
        w_wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    busy          = (r_state != S_IDLE);
    done          = 1'b0;
    fault         = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = 32'h0;
    mem.mem_wstrb = 4'b0000;
    case (r_state)
      S_REQ: begin
        mem.mem_req   = 1'b1;
        mem.mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
        mem.mem_we    = r_is_st;
        mem.mem_wdata = r_is_st ? w_wdata : 32'h0;
        mem.mem_wstrb = r_is_st ? w_wstrb : 4'b0000;
      end
      S_RESP: begin
        done  = 1'b1;
        fault = r_fault;
      end
      default: ;
    endcase
  end

  assign load_data = r_load_data;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed plan cases plus randomized accesses against an arithmetic model.
module tb_lsu;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy, done, fault;
  logic [31:0] load_data;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_ld = 32'h0;

  lsu_if #(.ADDR_W(32)) mem_bus ();

  lsu #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .opcode     (opcode),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .load_data  (load_data),
    .mem        (mem_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Caller is positioned just after a negedge; returns positioned the same way.
  task automatic access(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd, input int waits);
    bit          is_ld, is_st, legal, mis, flt;
    int          size, off;
    logic [31:0] mask, val, ewdata;
    logic [3:0]  estrb;
    is_ld = (op == OP_LOAD);
    is_st = (op == OP_STORE);
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = is_ld ? (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7) : (f3 <= 3'd2);
    mis   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = (a % size) != 0;
`endif
    flt    = !legal || mis;
    off    = (int'(a % 4) / size) * size;
    mask   = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
    val    = (rd >> (8 * off)) & mask;
    if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~mask;
    ewdata = (sd & mask) * ((size == 1) ? 32'h0101_0101 : (size == 2) ? 32'h0001_0001 : 32'h1);
    estrb  = 4'(((1 << size) - 1) << off);

    start      = 1'b1;
    opcode     = op;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    mem_bus.mem_ready = 1'($urandom_range(0, 1));
    mem_bus.mem_rdata = $urandom;
    @(negedge clk);
    start = 1'b0;
    chk("busy_c1", 32'(busy), 32'(is_ld || is_st));
    if (!(is_ld || is_st)) begin
      chk("ign_done", 32'(done), 32'h0);
      chk("ign_req", 32'(mem_bus.mem_req), 32'h0);
      return;
    end
    if (flt) begin
      chk("flt_done", 32'(done), 32'h1);
      chk("flt_fault", 32'(fault), 32'h1);
      chk("flt_req", 32'(mem_bus.mem_req), 32'h0);
      chk("flt_ld", load_data, exp_ld);
      @(negedge clk);
      chk("flt_busy_end", 32'(busy), 32'h0);
      chk("flt_done_end", 32'(done), 32'h0);
      return;
    end
    for (int w = 0; w <= waits; w++) begin
      if (w > 0) @(negedge clk);
      chk("req", 32'(mem_bus.mem_req), 32'h1);
      chk("req_addr", mem_bus.mem_addr, {a[31:2], 2'b00});
      chk("req_we", 32'(mem_bus.mem_we), 32'(is_st));
      chk("req_wstrb", 32'(mem_bus.mem_wstrb), 32'(is_st ? estrb : 4'b0000));
      if (is_st) chk("req_wdata", mem_bus.mem_wdata, ewdata);
      chk("req_done", 32'(done), 32'h0);
      chk("req_busy", 32'(busy), 32'h1);
      mem_bus.mem_ready = (w == waits);
      mem_bus.mem_rdata = (w == waits) ? rd : $urandom;
    end
    @(negedge clk);
    if (is_ld) exp_ld = val;
    chk("resp_done", 32'(done), 32'h1);
    chk("resp_fault", 32'(fault), 32'h0);
    chk("resp_ld", load_data, exp_ld);
    chk("resp_req", 32'(mem_bus.mem_req), 32'h0);
    chk("resp_busy", 32'(busy), 32'h1);
    mem_bus.mem_ready = 1'($urandom_range(0, 1));
    start  = 1'($urandom_range(0, 1));
    opcode = OP_LOAD;
    funct3 = 3'b010;
    @(negedge clk);
    start = 1'b0;
    chk("end_busy", 32'(busy), 32'h0);
    chk("end_done", 32'(done), 32'h0);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    opcode     = 7'h0;
    funct3     = 3'h0;
    addr       = 32'h0;
    store_data = 32'h0;
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_ld", load_data, 32'h0);
    chk("rst_req", 32'(mem_bus.mem_req), 32'h0);
    chk("rst_wstrb", 32'(mem_bus.mem_wstrb), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    access(OP_LOAD, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    chk("lw_val", load_data, 32'hDEADBEEF);
    access(OP_LOAD, 3'b000, 32'h103, 32'h0, 32'h80123456, 1);
    chk("lb_val", load_data, 32'hFFFFFF80);
    access(OP_LOAD, 3'b100, 32'h103, 32'h0, 32'h80123456, 0);
    chk("lbu_val", load_data, 32'h00000080);
    access(OP_STORE, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 0);
    chk("sh_keeps_ld", load_data, 32'h00000080);
    access(OP_STORE, 3'b000, 32'h10, 32'h000000A5, 32'h0, 3);
    access(OP_LOAD, 3'b010, 32'h101, 32'h0, 32'h12345678, 0);
    access(OP_LOAD, 3'b011, 32'h40, 32'h0, 32'h0, 0);
    access(OP_STORE, 3'b100, 32'h44, 32'h1, 32'h0, 0);
    access(OP_ALU, 3'b010, 32'h48, 32'h0, 32'h0, 0);

    // Abort a load during its second wait cycle.
    start  = 1'b1;
    opcode = OP_LOAD;
    funct3 = 3'b010;
    addr   = 32'h300;
    mem_bus.mem_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("abort_req1", 32'(mem_bus.mem_req), 32'h1);
    @(negedge clk);
    chk("abort_req2", 32'(mem_bus.mem_req), 32'h1);
    rst_n = 1'b0;
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("abort_req", 32'(mem_bus.mem_req), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_ld", load_data, 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    rst_n  = 1'b1;
    exp_ld = 32'h0;
    mem_bus.mem_ready = 1'b0;
    @(negedge clk);
    access(OP_LOAD, 3'b101, 32'h306, 32'h0, 32'h9ABC1234, 2);
    chk("post_rst_lhu", load_data, 32'h00009ABC);

    for (int i = 0; i < 200; i++) begin
      int          sel;
      logic [6:0]  op;
      sel = int'($urandom_range(0, 9));
      op  = (sel < 4) ? OP_LOAD : (sel < 8) ? OP_STORE : OP_ALU;
      access(op, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the ALU in the single-issue RISC-V datapath. It takes the effective address the ALU computes for `LOAD`/`STORE` opcodes (busA + imm on busC) together with the store operand, and runs one data-memory transaction per instruction through a req/ready handshake. It performs byte-lane steering, write-strobe generation and load sign/zero extension. It asserts `busy` so the control unit stalls the pipeline while an access is outstanding.

## Interface
Parameters:
- `ADDR_W`, 32: address width presented to data memory.

Ports:
- `clk` in 1: sole clock; all state updates on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: single-cycle request from control; sampled only in IDLE.
- `opcode` in 7: instruction opcode; only `LOAD`/`STORE` from util.v are accepted.
- `funct3` in 3: access size/signedness.
- `addr` in 32: effective address (ALU busC).
- `store_data` in 32: rs2 value (ALU busB).
- `busy` out 1: high from the cycle after an accepted `start` until `done` inclusive.
- `done` out 1: one-cycle completion pulse.
- `fault` out 1: valid with `done`; misaligned or illegal funct3.
- `load_data` out 32: extended load result; valid with `done`, held until the next load completes.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out ADDR_W (bits [1:0] always 0), `mem_wdata` out 32, `mem_wstrb` out 4.
- `mem_rdata` in 32, `mem_ready` in 1: memory read data and completion.

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE → REQ: `start`=1 and opcode is LOAD or STORE. Latch opcode, funct3, addr and store_data. `start` with any other opcode is ignored.
- IDLE → RESP: `start`=1 on a faulting access. No memory request is issued; `fault`=1.
- REQ: `mem_req`=1. Address, write enable, write data and strobes are held stable until `mem_ready`=1 is sampled. Then the state moves to RESP; on a load, `mem_rdata` is captured.
- RESP: `done`=1 for exactly one cycle, then IDLE. `start` in RESP is ignored.
- Load funct3 decoding:
  - 000 LB: sign-extend byte at offset addr[1:0].
  - 001 LH: sign-extend halfword at offset addr[1]*16.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend halfword.
  - Other values: illegal.
- Store funct3 decoding:
  - 000 SB: byte replicated ×4; wstrb = 0001 << addr[1:0].
  - 001 SH: halfword replicated ×2; wstrb = 0011 << addr[1]*2.
  - 010 SW: wstrb = 1111.
  - Other values: illegal.
- `mem_we`=0 and `mem_wstrb`=0000 for loads.
- A store never modifies `load_data`. A faulting load leaves `load_data` unchanged.
- Reset values: state IDLE; all outputs 0, including `load_data`.
- Reset mid-transaction: at the first edge with `rst_n`=0, the FSM returns to IDLE and `mem_req` drops. There is no completion pulse for the aborted access.

## Timing
- Zero-wait memory (`mem_ready`=1 in the first REQ cycle): `start` in cycle 0, `mem_req` in cycle 1, `done` in cycle 2. Total latency is 2 cycles.
- Each wait cycle on `mem_ready` adds one cycle.
- A faulting access has `done` in cycle 1.
- `busy` rises in the cycle after `start`, and falls in the cycle after `done`. A new `start` is accepted in that same cycle.
- `mem_ready` outside REQ is ignored.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - LH/LHU/SH with addr[0]=1 is a fault.
  - LW/SW with addr[1:0]≠00 is a fault.
  - Faults complete via RESP with `fault`=1 and no bus cycle.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - Low address bits below the access size are forced to zero: halfword uses addr[0]=0, word uses addr[1:0]=00.
  - The access proceeds normally.
  - `fault` is raised only for illegal funct3.

## Test plan
- LW, addr=0x100, `mem_rdata`=0xDEADBEEF, `mem_ready` immediate → `mem_addr`=0x100, `done` in cycle 2, `load_data`=0xDEADBEEF, `fault`=0.
- LB, addr=0x103, `mem_rdata`=0x80123456 → `load_data`=0xFFFFFF80. Same access with LBU → 0x00000080.
- SH, addr=0x202, store_data=0x0000ABCD → `mem_wdata`=0xABCDABCD, `mem_wstrb`=1100, `mem_addr`=0x200, `mem_we`=1.
- SB, addr=0x10, `mem_ready` held low for 3 cycles → `mem_req`/`mem_addr`/`mem_wstrb`=0001 stable throughout, `done` in cycle 5, `busy` high cycles 1–5.
- LW, addr=0x101:
  - With `LSU_MISALIGN_TRAP_EN`: `mem_req` never asserts; `done` and `fault`=1 in cycle 1.
  - Without it: `mem_addr`=0x100 and the load completes normally.
- `rst_n` driven low during the 2nd REQ wait cycle → next edge: `mem_req`=0, `busy`=0, `load_data`=0, no `done`. A subsequent `start` is accepted normally.
